dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that services the load/store requests the pipeline issues from its MEM stage. It serves memread/memwrite strobes, address and store data, holds the pipeline with a stall until the access completes, and returns load data with a one-cycle completion pulse. It replaces the zero-latency data memory when modelling realistic memory timing.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 2
- LATENCY, 3: cycles from request to completion; at least 1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- memread_i  in  1  load request, from the EX/MEM register
- memwrite_i  in  1  store request, from the EX/MEM register
- memaddr_i  in  32  byte address (ALU result)
- writedata_i  in  32  store data (rt)
- memdata_o  out  32  load data, registered
- valid_o  out  1  completion pulse, registered
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; combinational from state and request
- err_o  out  1  access error, registered; present only with DMEM_ERR_EN

## Operation
- req = memread_i | memwrite_i. Word index = memaddr_i[log2(DEPTH)+1:2].
- FSM states: IDLE, WAIT, DONE.
- IDLE with req: accept the request. If LATENCY==1, go to DONE; otherwise go to WAIT with cnt=LATENCY-2.
- IDLE without req: stay in IDLE.
- WAIT: if cnt==0, go to DONE; otherwise decrement cnt. The request inputs are held stable by the stall; they are not re-sampled.
- DONE: always go to IDLE. The pipeline advances at the end of this cycle, so the next IDLE cycle sees the next instruction's request.
- stall_o = (IDLE & req) | WAIT. It is 0 in DONE.
- On the edge entering DONE:
  - Store: the array word is written.
  - Load: memdata_o is loaded with the word.
  - Both strobes high: read-before-write. memdata_o gets the old word and the array gets writedata_i.
- memdata_o holds its value until the next load completes. Stores leave memdata_o unchanged.
- valid_o is 1 only in DONE.
- The array is not cleared by reset. The bench preloads it hierarchically.

## Timing
- Reset values: state IDLE, cnt 0, memdata_o 0, valid_o 0, err_o 0. stall_o is 0 while rst_i is low.
- A request first seen in cycle T:
  - stall_o is high in cycles T through T+LATENCY-1 (exactly LATENCY cycles).
  - valid_o and memdata_o are valid in cycle T+LATENCY.
- Back-to-back memory instructions: each costs LATENCY+1 cycles, with one DONE cycle between stalls.
- Reset asserted mid-access: return to IDLE immediately. A pending store is discarded, since commit only happens at DONE entry, and no valid_o is produced.
- Request deasserted while in WAIT: ignored, the access still completes. This is illegal stimulus; the bench asserts it never happens.
- No combinational path from memaddr_i or writedata_i to any output. stall_o depends only on the strobes and state.

## Configuration
- DMEM_ERR_EN defined:
  - err_o exists.
  - A request is an error if memaddr_i[1:0]!=0, or if memaddr_i >= DEPTH*4.
  - An erroring request keeps the same latency and handshake.
  - Its store is suppressed, memdata_o is loaded with 0, and err_o=1 together with valid_o in DONE.
- DMEM_ERR_EN undefined:
  - No err_o port and no checking.
  - memaddr_i[1:0] is ignored and upper address bits are truncated, so the word index wraps modulo DEPTH.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - the default DEPTH and LATENCY constants;
  - the localparam for the counter width, $clog2(LATENCY) with a minimum of 1.
- Sub-module dmem_array holds the word storage: one synchronous write port and one synchronous read port, enabled on DONE entry. The FSM, counter and error logic stay in dmem_responder.

## Test plan
- Reset, then a load from 0x10 with word 4 preloaded to 0xDEADBEEF, LATENCY=3 → stall_o high for 3 cycles, then valid_o=1 with memdata_o=0xDEADBEEF in the 4th cycle, stall_o=0.
- Store 0x12345678 to 0x20, then load from 0x20 → the load returns 0x12345678. memdata_o is unchanged after the store.
- Two consecutive loads, LATENCY=1 → stall pattern 1,0,1,0. The two valid_o pulses are 2 cycles apart.
- Store to 0x40 with rst_i pulsed low in the second WAIT cycle → FSM returns to IDLE, no valid_o, word 16 keeps its old value.
- Read and write strobes both high at 0x8, old word 0xAAAA0000, writedata 0x5555 → memdata_o=0xAAAA0000 and the array then holds 0x5555.
- With DMEM_ERR_EN: store to 0x22 → err_o=1 and valid_o=1 after LATENCY cycles, words 8 and 9 unchanged. With DEPTH=256, a load from 0x400 → err_o=1 and memdata_o=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 3;

    // The wait counter starts at LATENCY-2, so $clog2(LATENCY) bits always suffice.
    function automatic int cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_LATENCY);

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: one synchronous write port and one
// synchronous read port sharing a word index, both strobed on DONE entry.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register is reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    // A same-edge write is not yet visible here, which gives read-before-write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY cycles per
// access and completes with a one-cycle valid pulse. DMEM_ERR_EN adds err_o.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] memaddr_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] memdata_o,
    output logic        valid_o,
    output logic        stall_o
`ifdef DMEM_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req;
    logic             accept;
    logic             enter_done;

    logic             req_err;
    logic [IDX_W-1:0] req_idx;

    logic             rd_q, wr_q, err_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;

    logic             commit_rd, commit_wr, commit_err;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_wdata;

    assign req     = memread_i | memwrite_i;
    assign req_idx = memaddr_i[IDX_W+1:2];

`ifdef DMEM_ERR_EN
    assign req_err = (memaddr_i[1:0] != 2'b00) || (|memaddr_i[31:IDX_W+2]);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memaddr_i[31:IDX_W+2], memaddr_i[1:0]};
    assign req_err          = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_done = 1'b0;
        stall_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    if (LATENCY == 1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst_i) begin
            stall_o = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request is captured once at acceptance; later input changes are not re-sampled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rd_q    <= memread_i;
            wr_q    <= memwrite_i;
            err_q   <= req_err;
            idx_q   <= req_idx;
            wdata_q <= writedata_i;
        end
    end

    // With LATENCY==1 the commit edge is the accept edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            commit_rd    = memread_i;
            commit_wr    = memwrite_i;
            commit_err   = req_err;
            commit_idx   = req_idx;
            commit_wdata = writedata_i;
        end else begin
            commit_rd    = rd_q;
            commit_wr    = wr_q;
            commit_err   = err_q;
            commit_idx   = idx_q;
            commit_wdata = wdata_q;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (enter_done & commit_wr & ~commit_err),
        .rd_en   (enter_done & (commit_rd | commit_err)),
        .rd_zero (commit_err),
        .idx     (commit_idx),
        .wdata   (commit_wdata),
        .rdata   (memdata_o)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
`ifdef DMEM_ERR_EN
            err_o   <= 1'b0;
`endif
        end else begin
            valid_o <= enter_done;
`ifdef DMEM_ERR_EN
            err_o   <= enter_done & commit_err;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a word-array model predicts stall,
// valid, memdata (and err under DMEM_ERR_EN) every cycle, plus literal pins.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread, memwrite;
    logic [31:0] addr, wdata;
    logic [31:0] memdata;
    logic        valid, stall;
    logic        rd1, wr1;
    logic [31:0] addr1, wd1;
    logic [31:0] md1;
    logic        v1, s1;
`ifdef DMEM_ERR_EN
    logic        err, e1;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .memread_i   (memread),
        .memwrite_i  (memwrite),
        .memaddr_i   (addr),
        .writedata_i (wdata),
        .memdata_o   (memdata),
        .valid_o     (valid),
        .stall_o     (stall)
`ifdef DMEM_ERR_EN
        ,
        .err_o       (err)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .memread_i   (rd1),
        .memwrite_i  (wr1),
        .memaddr_i   (addr1),
        .writedata_i (wd1),
        .memdata_o   (md1),
        .valid_o     (v1),
        .stall_o     (s1)
`ifdef DMEM_ERR_EN
        ,
        .err_o       (e1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected word contents and expected outputs for the current cycle.
    logic [31:0] mem_m [DEPTH];
    logic        exp_stall, exp_valid, exp_err;
    logic [31:0] exp_data;
    bit          cmp_en;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("valid", 32'(valid), 32'(exp_valid));
            check("memdata", memdata, exp_data);
`ifdef DMEM_ERR_EN
            check("err", 32'(err), 32'(exp_err));
`endif
            if (stall) check("req_held_while_stalled", 32'(memread | memwrite), 32'd1);
        end
    end

    int cyc = 0;
    int stall_cycles = 0;
    int v1_count = 0;
    int v1_cyc [2];

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (stall) stall_cycles++;
        if (v1) begin
            if (v1_count < 2) v1_cyc[v1_count] = cyc;
            v1_count++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            exp_stall = 1'b0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end
    endtask

    // One memory instruction: request in cycle T, DONE in cycle T+LAT.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int idx;
        bit bad;
        idx = int'(a >> 2) % DEPTH;
        bad = 1'b0;
`ifdef DMEM_ERR_EN
        bad = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`endif
        @(posedge clk); #1;
        memread   = rd;
        memwrite  = wr;
        addr      = a;
        wdata     = wd;
        exp_stall = 1'b1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        exp_stall = 1'b0;
        exp_valid = 1'b1;
        exp_err   = bad;
        if (bad) begin
            exp_data = 32'h0;
        end else begin
            if (rd) exp_data = mem_m[idx];
            if (wr) mem_m[idx] = wd;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        memread = 1'b1; memwrite = 1'b0; addr = 32'h10; wdata = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        cmp_en = 1'b0;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_data = '0;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'hC0DE_0000 | 32'(i);
        mem_m[4]  = 32'hDEADBEEF;
        mem_m[2]  = 32'hAAAA0000;
        mem_m[16] = 32'h0BADF00D;
        for (int i = 0; i < DEPTH; i++) begin
            dut.u_array.mem[i]  = mem_m[i];
            dut1.u_array.mem[i] = mem_m[i];
        end

        // Reset values, with a request already pending during reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_memdata", memdata, 32'd0);
        check("reset_stall_lat1", 32'(s1), 32'd0);
        memread = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Load from 0x10: three stall cycles then DEADBEEF.
        stall_cycles = 0;
        access(1'b1, 1'b0, 32'h10, 32'h0);
        check("load_0x10_literal", memdata, 32'hDEADBEEF);
        check("load_0x10_stall_cycles", 32'(stall_cycles), 32'd3);

        // Store then load back; the store leaves memdata alone.
        access(1'b0, 1'b1, 32'h20, 32'h12345678);
        check("store_keeps_memdata", memdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        check("load_0x20_literal", memdata, 32'h12345678);
        idle(1);

        // Store to 0x40 aborted by reset in its second WAIT cycle.
        @(posedge clk); #1;
        memwrite = 1'b1; addr = 32'h40; wdata = 32'h11112222;
        exp_stall = 1'b1; exp_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        memwrite = 1'b0;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_data = 32'h0;
        #2 rst_n = 1'b1;
        idle(3);
        access(1'b1, 1'b0, 32'h40, 32'h0);
        check("aborted_store_word16", memdata, 32'h0BADF00D);

        // Both strobes: read-before-write.
        access(1'b1, 1'b1, 32'h8, 32'h5555);
        check("rbw_old_word", memdata, 32'hAAAA0000);
        access(1'b1, 1'b0, 32'h8, 32'h0);
        check("rbw_new_word", memdata, 32'h00005555);

`ifdef DMEM_ERR_EN
        access(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF);
        check("misaligned_err", 32'(err), 32'd1);
        check("misaligned_valid", 32'(valid), 32'd1);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        check("word8_unchanged", memdata, 32'h12345678);
        access(1'b1, 1'b0, 32'h24, 32'h0);
        check("word9_unchanged", memdata, 32'hC0DE0009);
        access(1'b1, 1'b0, 32'h400, 32'h0);
        check("oob_err", 32'(err), 32'd1);
        check("oob_memdata", memdata, 32'h0);
`else
        // Upper address bits and the byte offset are ignored: 0x413 maps to word 4.
        access(1'b1, 1'b0, 32'h413, 32'h0);
        check("wrap_word4", memdata, 32'hDEADBEEF);
`endif
        idle(1);

        // LATENCY=1 instance: two back-to-back loads.
        v1_count = 0;
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'h10;
        @(negedge clk);
        check("lat1_stall_0", 32'(s1), 32'd1);
        check("lat1_valid_0", 32'(v1), 32'd0);
        @(posedge clk); #1;
        addr1 = 32'h14;
        @(negedge clk);
        check("lat1_stall_1", 32'(s1), 32'd0);
        check("lat1_valid_1", 32'(v1), 32'd1);
        check("lat1_data_1", md1, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat1_stall_2", 32'(s1), 32'd1);
        check("lat1_valid_2", 32'(v1), 32'd0);
        @(posedge clk); #1;
        rd1 = 1'b0;
        @(negedge clk);
        check("lat1_stall_3", 32'(s1), 32'd0);
        check("lat1_valid_3", 32'(v1), 32'd1);
        check("lat1_data_3", md1, 32'hC0DE0005);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat1_valid_after", 32'(v1), 32'd0);
        check("lat1_pulse_count", 32'(v1_count), 32'd2);
        check("lat1_pulse_spacing", 32'(v1_cyc[1] - v1_cyc[0]), 32'd2);

        idle(2);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
